mac_array_seq: RTL and testbench
================================

// Module: mac_array_seq
// PURPOSE
// - Parametrised, feature-serial successor to the 4-node combinational MAC bank in the GNN aggregation/update stage.
// - Computes out[n][o] = sum_k x[n][k]*w[k][o] for NODES nodes and OUT_FEAT output features.
// - Consumes one input-feature column per accepted beat. All nodes share the weight row of that beat.
// - Results are held behind a valid/ready output handshake until the downstream ReLU/writeback stage takes them.
// PARAMETERS
// - NODES     4   nodes processed in parallel (>=1)
// - IN_FEAT   4   maximum input features per vector, i.e. beats per job (>=1)
// - OUT_FEAT  4   output features per node (>=1)
// - IN_W      7   signed input feature width
// - W_W       5   signed weight width
// - OUT_W     13  signed accumulator/output width (>= IN_W+W_W)
// PORTS
// - clk       in   1                      clock, rising edge
// - rst_n     in   1                      asynchronous active-low reset
// - in_valid  in   1                      input beat valid
// - in_ready  out  1                      block can accept a beat
// - in_last   in   1                      beat is the final feature of the job
// - x_col     in   NODES*IN_W             feature k of each node; node n at [n*IN_W +: IN_W]
// - w_row     in   OUT_FEAT*W_W           weight row k; output o at [o*W_W +: W_W]
// - out_valid out  1                      results valid, held stable until taken
// - out_ready in   1                      downstream accepts results
// - out_data  out  NODES*OUT_FEAT*OUT_W   out[n][o] at [(n*OUT_FEAT+o)*OUT_W +: OUT_W]
// - out_ovf   out  1                      sticky per job: some accumulation overflowed OUT_W
// BEHAVIOUR
// - Clock and reset: one clock domain. rst_n is asynchronous and active-low.
// - Reset values: state=RUN, k=0, first=1, all accumulators 0, out_valid=0, out_ovf=0, in_ready=1.
// - FSM RUN:
//   - in_ready=1, out_valid=0.
//   - A beat is accepted when in_valid && in_ready.
//   - On the first beat of a job, acc[n][o] <= x[n]*w[o]. On later beats, acc[n][o] <= acc[n][o] + x[n]*w[o].
//   - Products are full precision (IN_W+W_W bits) and sign-extended to OUT_W.
//   - k counts accepted beats.
//   - The accepted beat ends the job when in_last=1 or k==IN_FEAT-1. Either condition moves the FSM to DONE.
//   - Reaching IN_FEAT beats without in_last is a forced end. It is not an error flag.
// - FSM DONE:
//   - in_ready=0, out_valid=1.
//   - out_data and out_ovf are stable.
//   - On out_valid && out_ready: go to RUN, k=0, first=1, out_ovf cleared. Accumulators are not cleared; the next first beat overwrites them.
// - Latency: out_valid rises on the cycle after the last beat is accepted. A job of K beats needs K+1 cycles minimum.
// - Throughput: one job every K+1 cycles when out_ready is held high.
// - Backpressure: out_ready low in DONE stalls indefinitely, with in_ready held low.
// - Input gaps: in_valid low in RUN inserts bubbles. No state changes during a bubble.
// - Simultaneous events: no beat can be accepted in DONE, so output handoff and input acceptance never overlap.
// - Overflow: out_ovf sets when any add or load overflows signed OUT_W.
// - Reset mid-job: partial sums are discarded and all outputs return to reset values immediately.
// CONFIGURATION
// - MAC_ARRAY_SAT_EN defined: each add saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_ovf still flags saturation.
// - MAC_ARRAY_SAT_EN undefined: two's-complement wrap at OUT_W. out_ovf flags the wrap.
// TESTING
// - Reset: assert rst_n=0 mid-job after 2 beats, then release.
//   -> out_valid=0 and in_ready=1; the next job's result excludes the aborted beats.
// - Default params, all x=1, all w=1, 4 beats with in_last on the 4th.
//   -> every out=4; out_valid rises 1 cycle after beat 4; out_ovf=0.
// - Node 0 x=-64, w=-16, 1 beat with in_last.
//   -> out[0][*]=1024. Other nodes with x=3, w=-16 -> -48. Checks short job and sign handling.
// - 4 beats with no in_last.
//   -> forced end after beat 4: out_valid=1 and in_ready=0.
//   -> hold out_ready=0 for 10 cycles -> out_data stable and no beat accepted.
// - x=63, w=15, 4 beats: sum 3780 fits. Then OUT_W=11 build, same stimulus:
//   -> wrap build: out=3780 mod 2^11 signed (-316), out_ovf=1.
//   -> MAC_ARRAY_SAT_EN build: out=1023, out_ovf=1.
// - Back-to-back jobs with random in_valid gaps and out_ready stalls, plus NODES=8 and OUT_FEAT=2 builds.
//   -> every result matches the reference model.

Source files
------------

// File: rtl/mac_array_seq.sv
// Feature-serial MAC bank: one input-feature column per beat, NODES x OUT_FEAT accumulators.
// Optional macro MAC_ARRAY_SAT_EN: saturate accumulations instead of two's-complement wrap.
module mac_array_seq #(
  parameter int NODES    = 4,
  parameter int IN_FEAT  = 4,
  parameter int OUT_FEAT = 4,
  parameter int IN_W     = 7,
  parameter int W_W      = 5,
  parameter int OUT_W    = 13
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [NODES*IN_W-1:0]           x_col,
  input  logic [OUT_FEAT*W_W-1:0]         w_row,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NODES*OUT_FEAT*OUT_W-1:0] out_data,
  output logic                            out_ovf
);

  localparam int PW = IN_W + W_W;
  // Extended width holds any load or acc+product without losing the true value.
  localparam int EW = ((PW > OUT_W) ? PW : OUT_W) + 1;
  localparam int KW = (IN_FEAT > 1) ? $clog2(IN_FEAT) : 1;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] DONE = 1'b1;

  localparam logic signed [EW-1:0] ACC_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] ACC_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [KW-1:0]        K_LAST  = KW'(IN_FEAT - 1);

  function automatic logic acc_ovf(input logic signed [EW-1:0] v);
    return (v > ACC_MAX) || (v < ACC_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] acc_fit(input logic signed [EW-1:0] v);
`ifdef MAC_ARRAY_SAT_EN
    if (v > ACC_MAX) begin
      return ACC_MAX[OUT_W-1:0];
    end else if (v < ACC_MIN) begin
      return ACC_MIN[OUT_W-1:0];
    end else begin
      return v[OUT_W-1:0];
    end
`else
    return v[OUT_W-1:0];
`endif
  endfunction

  logic [0:0]              state_r;
  logic [KW-1:0]           k_r;
  logic                    first_r;
  logic                    in_ready_r;
  logic                    out_valid_r;
  logic                    ovf_r;
  logic signed [OUT_W-1:0] acc_r   [NODES][OUT_FEAT];
  logic signed [PW-1:0]    prod_s  [NODES][OUT_FEAT];
  logic signed [EW-1:0]    ext_s   [NODES][OUT_FEAT];
  logic signed [EW-1:0]    sum_s   [NODES][OUT_FEAT];
  logic                    ovf_any_s;
  logic                    accept_s;
  logic                    job_end_s;

  assign accept_s  = in_valid && in_ready_r;
  assign job_end_s = accept_s && (in_last || (k_r == K_LAST));

  // Products of the current beat and the exact (unwrapped) next accumulator values.
  always_comb begin
    ovf_any_s = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      for (int o = 0; o < OUT_FEAT; o++) begin
        prod_s[n][o] = $signed(x_col[n*IN_W +: IN_W]) * $signed(w_row[o*W_W +: W_W]);
        ext_s[n][o]  = prod_s[n][o];
        if (first_r) begin
          sum_s[n][o] = ext_s[n][o];
        end else begin
          sum_s[n][o] = ext_s[n][o] + acc_r[n][o];
        end
        if (acc_ovf(sum_s[n][o])) begin
          ovf_any_s = 1'b1;
        end else begin
          ovf_any_s = ovf_any_s;
        end
      end
    end
  end

  // Job sequencing, accumulation and output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      k_r         <= '0;
      first_r     <= 1'b1;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      for (int n = 0; n < NODES; n++) begin
        for (int o = 0; o < OUT_FEAT; o++) begin
          acc_r[n][o] <= '0;
        end
      end
    end else begin
      case (state_r)
        RUN: begin
          if (accept_s) begin
            for (int n = 0; n < NODES; n++) begin
              for (int o = 0; o < OUT_FEAT; o++) begin
                acc_r[n][o] <= acc_fit(sum_s[n][o]);
              end
            end
            first_r <= 1'b0;
            ovf_r   <= ovf_r | ovf_any_s;
            if (job_end_s) begin
              state_r     <= DONE;
              k_r         <= '0;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              k_r <= k_r + KW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= RUN;
            k_r         <= '0;
            first_r     <= 1'b1;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= RUN;
          k_r         <= '0;
          first_r     <= 1'b1;
          ovf_r       <= 1'b0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_ovf   = ovf_r;

  for (genvar gn = 0; gn < NODES; gn++) begin : g_node
    for (genvar go = 0; go < OUT_FEAT; go++) begin : g_feat
      assign out_data[(gn*OUT_FEAT+go)*OUT_W +: OUT_W] = acc_r[gn][go];
    end
  end

endmodule

// File: tb/tb_mac_array_seq.sv
// Randomised self-checking bench for mac_array_seq against an integer reference model.
module tb_mac_array_seq #(
  parameter int NODES    = 4,
  parameter int IN_FEAT  = 4,
  parameter int OUT_FEAT = 4,
  parameter int IN_W     = 7,
  parameter int W_W      = 5,
  parameter int OUT_W    = 13
);

  logic                            clk;
  logic                            rst_n;
  logic                            in_valid;
  logic                            in_ready;
  logic                            in_last;
  logic [NODES*IN_W-1:0]           x_col;
  logic [OUT_FEAT*W_W-1:0]         w_row;
  logic                            out_valid;
  logic                            out_ready;
  logic [NODES*OUT_FEAT*OUT_W-1:0] out_data;
  logic                            out_ovf;

  int checks   = 0;
  int failures = 0;

  int     xs [IN_FEAT][NODES];
  int     ws [IN_FEAT][OUT_FEAT];
  longint exp_acc [NODES][OUT_FEAT];
  longint exp_ovf;

  mac_array_seq #(
    .NODES(NODES), .IN_FEAT(IN_FEAT), .OUT_FEAT(OUT_FEAT),
    .IN_W(IN_W), .W_W(W_W), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .x_col(x_col), .w_row(w_row),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint dut_out(input int n, input int o);
    logic signed [OUT_W-1:0] v;
    v = out_data[(n*OUT_FEAT+o)*OUT_W +: OUT_W];
    return longint'(v);
  endfunction

  // Reference: out[n][o] = sum_k x*w, range-limited after every load/add.
  task automatic model(input int nbeats);
    longint lim_hi, lim_lo, span, v;
    lim_hi  = (longint'(1) <<< (OUT_W-1)) - 1;
    lim_lo  = -(longint'(1) <<< (OUT_W-1));
    span    = longint'(1) <<< OUT_W;
    exp_ovf = 0;
    for (int n = 0; n < NODES; n++) begin
      for (int o = 0; o < OUT_FEAT; o++) begin
        v = 0;
        for (int b = 0; b < nbeats; b++) begin
          v = v + longint'(xs[b][n]) * longint'(ws[b][o]);
          if (v > lim_hi || v < lim_lo) begin
            exp_ovf = 1;
`ifdef MAC_ARRAY_SAT_EN
            v = (v > lim_hi) ? lim_hi : lim_lo;
`else
            v = ((v % span) + span) % span;
            if (v > lim_hi) v = v - span;
`endif
          end
        end
        exp_acc[n][o] = v;
      end
    end
  endtask

  task automatic check_results(input string tag);
    for (int n = 0; n < NODES; n++)
      for (int o = 0; o < OUT_FEAT; o++)
        chk($sformatf("%s_out[%0d][%0d]", tag, n, o), dut_out(n, o), exp_acc[n][o]);
    chk({tag, "_ovf"}, longint'(out_ovf), exp_ovf);
  endtask

  function automatic int rnd_x();
    return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W-1));
  endfunction

  function automatic int rnd_w();
    return int'($urandom_range(0, (1 << W_W) - 1)) - (1 << (W_W-1));
  endfunction

  task automatic fill_random();
    for (int b = 0; b < IN_FEAT; b++) begin
      for (int n = 0; n < NODES; n++) xs[b][n] = rnd_x();
      for (int o = 0; o < OUT_FEAT; o++) ws[b][o] = rnd_w();
    end
  endtask

  task automatic fill_const(input int xv, input int wv);
    for (int b = 0; b < IN_FEAT; b++) begin
      for (int n = 0; n < NODES; n++) xs[b][n] = xv;
      for (int o = 0; o < OUT_FEAT; o++) ws[b][o] = wv;
    end
  endtask

  task automatic drive_beat(input int b, input logic last);
    for (int n = 0; n < NODES; n++) x_col[n*IN_W +: IN_W] = IN_W'(xs[b][n]);
    for (int o = 0; o < OUT_FEAT; o++) w_row[o*W_W +: W_W] = W_W'(ws[b][o]);
    in_last  = last;
    in_valid = 1'b1;
  endtask

  // One complete job: beats with random bubbles, result check, stall, handoff.
  task automatic run_job(input string tag, input int nbeats, input bit use_last,
                         input int gap_pct, input int stall);
    for (int b = 0; b < nbeats; b++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      drive_beat(b, logic'(use_last && (b == nbeats - 1)));
      chk({tag, "_in_ready"}, longint'(in_ready), 1);
      chk({tag, "_early_valid"}, longint'(out_valid), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_latency_valid"}, longint'(out_valid), 1);
    chk({tag, "_done_in_ready"}, longint'(in_ready), 0);
    model(nbeats);
    check_results(tag);
    for (int s = 0; s < stall; s++) begin
      for (int n = 0; n < NODES; n++) x_col[n*IN_W +: IN_W] = IN_W'(rnd_x());
      for (int o = 0; o < OUT_FEAT; o++) w_row[o*W_W +: W_W] = W_W'(rnd_w());
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (stall > 0) begin
      chk({tag, "_stall_valid"}, longint'(out_valid), 1);
      chk({tag, "_stall_in_ready"}, longint'(in_ready), 0);
      check_results({tag, "_stall"});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_handoff_valid"}, longint'(out_valid), 0);
    chk({tag, "_handoff_ovf"}, longint'(out_ovf), 0);
    chk({tag, "_handoff_in_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    int nb;
    bit ul;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    x_col     = '0;
    w_row     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_ovf", longint'(out_ovf), 0);
    chk("rst_out_data", longint'(out_data == '0), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All ones, full-length job ended by in_last.
    fill_const(1, 1);
    run_job("ones", IN_FEAT, 1'b1, 0, 0);

    // Single-beat job with sign handling on node 0.
    fill_const(3, -16);
    xs[0][0] = -(1 << (IN_W-1));
    run_job("short", 1, 1'b1, 0, 0);

    // Forced end without in_last, then a 10-cycle output stall.
    fill_random();
    run_job("forced", IN_FEAT, 1'b0, 0, 10);

    // Largest positive operands over a full job.
    fill_const((1 << (IN_W-1)) - 1, (1 << (W_W-1)) - 1);
    run_job("maxpos", IN_FEAT, 1'b1, 0, 0);

    // Most negative operands: products are large and positive.
    fill_const(-(1 << (IN_W-1)), -(1 << (W_W-1)));
    run_job("maxneg", IN_FEAT, 1'b1, 0, 0);

    // Reset in the middle of a job discards the partial sums.
    fill_const(5, 7);
    nb = (IN_FEAT > 2) ? 2 : IN_FEAT - 1;
    for (int b = 0; b < nb; b++) begin
      drive_beat(b, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_data", longint'(out_data == '0), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_random();
    run_job("after_rst", 1, 1'b1, 0, 0);

    // Back-to-back random jobs with bubbles and stalls.
    for (int j = 0; j < 60; j++) begin
      fill_random();
      nb = int'($urandom_range(1, IN_FEAT));
      ul = (nb < IN_FEAT) ? 1'b1 : bit'($urandom_range(0, 1));
      run_job($sformatf("rnd%0d", j), nb, ul, 30, int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
